game_score_ctrl: RTL



---
 rtl/game_score_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/game_score_ctrl.sv
// game_score_ctrl: round timer, BCD score and lives keeper for the zombie-hit game.
// Optional `define COMBO_BONUS_EN: every 5th consecutive hit scores 2 instead of 1.
module game_score_ctrl #(
    parameter int TICK_DIV     = 50000000,
    parameter int GAME_SECONDS = 30,
    parameter int INIT_LIVES   = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        hit,
    input  logic        fail,
    output logic        end_flag,
    output logic [15:0] score_bcd,
    output logic [7:0]  time_bcd,
    output logic [2:0]  lives,
    output logic [1:0]  state
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0] TIME_INIT = 8'((GAME_SECONDS / 10) * 16 + GAME_SECONDS % 10);
    localparam logic [2:0] LIVES_INIT = 3'(INIT_LIVES);

    typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, OVER = 2'b10} state_t;

    state_t st, st_n;
    logic [PW-1:0] pre, pre_n;
    logic [15:0] score_n;
    logic [7:0] time_n;
    logic [2:0] lives_n;
    logic start_q, hit_q, fail_q;
    logic start_e, hit_e, fail_e, lose_e, tick;
    logic [1:0] inc;
`ifdef COMBO_BONUS_EN
    logic [2:0] streak, streak_n;
`endif

    // Adds n to a 4-digit BCD value; a carry out of the top digit saturates at 9999
    function automatic logic [15:0] bcd_add(input logic [15:0] s, input logic [1:0] n);
        logic [15:0] r;
        logic [4:0] d;
        logic c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = {1'b0, s[4*i +: 4]} + ((i == 0) ? {3'b0, n} : {4'b0, c});
            c = d > 5'd9;
            r[4*i +: 4] = c ? 4'(d - 5'd10) : d[3:0];
        end
        return c ? 16'h9999 : r;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] t);
        return (t[3:0] == 4'd0) ? {t[7:4] - 4'd1, 4'd9} : {t[7:4], t[3:0] - 4'd1};
    endfunction

    assign start_e = start & ~start_q;
    assign hit_e   = hit & ~hit_q;
    assign fail_e  = fail & ~fail_q;
    assign lose_e  = fail_e & ~hit_e;
    assign tick    = pre == PRE_MAX;
    assign state   = st;
`ifdef COMBO_BONUS_EN
    assign inc = (streak == 3'd4) ? 2'd2 : 2'd1;
`else
    assign inc = 2'd1;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            st        <= IDLE;
            pre       <= '0;
            score_bcd <= '0;
            time_bcd  <= TIME_INIT;
            lives     <= LIVES_INIT;
            end_flag  <= 1'b0;
            start_q   <= 1'b0;
            hit_q     <= 1'b0;
            fail_q    <= 1'b0;
`ifdef COMBO_BONUS_EN
            streak    <= '0;
`endif
        end else begin
            st        <= st_n;
            pre       <= pre_n;
            score_bcd <= score_n;
            time_bcd  <= time_n;
            lives     <= lives_n;
            end_flag  <= st_n == OVER;
            start_q   <= start;
            hit_q     <= hit;
            fail_q    <= fail;
`ifdef COMBO_BONUS_EN
            streak    <= streak_n;
`endif
        end
    end

    always_comb begin
        st_n    = st;
        pre_n   = pre;
        score_n = score_bcd;
        time_n  = time_bcd;
        lives_n = lives;
`ifdef COMBO_BONUS_EN
        streak_n = streak;
`endif
        case (st)
            IDLE: begin
                if (start_e) begin
                    st_n  = PLAY;
                    pre_n = '0;
                end
            end
            PLAY: begin
                pre_n = tick ? '0 : pre + 1'b1;
                if (tick && time_bcd != 8'h00) time_n = bcd_dec(time_bcd);
                if (hit_e) begin
                    score_n = bcd_add(score_bcd, inc);
`ifdef COMBO_BONUS_EN
                    streak_n = (streak == 3'd4) ? 3'd0 : streak + 3'd1;
`endif
                end else if (fail_e) begin
                    lives_n = (lives != 3'd0) ? lives - 3'd1 : lives;
`ifdef COMBO_BONUS_EN
                    streak_n = 3'd0;
`endif
                end
                // Timeout and last life may coincide; both just lead to OVER
                if ((tick && time_bcd == 8'h01) || (lose_e && lives == 3'd1)) st_n = OVER;
            end
            OVER: begin
                if (start_e) begin
                    st_n    = PLAY;
                    pre_n   = '0;
                    score_n = '0;
                    time_n  = TIME_INIT;
                    lives_n = LIVES_INIT;
`ifdef COMBO_BONUS_EN
                    streak_n = 3'd0;
`endif
                end
            end
            default: st_n = IDLE;
        endcase
    end
endmodule
